// File: rtl/psum_pingpong_buffer.sv
// psum_pingpong_buffer: multi-bank partial-sum buffer sitting between the MAC
// array and the layer sequencer. The MACs read bank[rd_ptr]; accumulator
// write-back lands in the following bank, saturated to PSUM_W. An optional
// shifted/saturated copy feeds the store path. A small FSM sequences bias
// broadcast and clear across all banks; chunk writes hit bank 0 directly.
// Optional feature macro: PSUM_SAT_CNT_EN (adds the sat_cnt port and counter).
module psum_pingpong_buffer #(
    parameter int LANES       = 112,
    parameter int ACC_W       = 33,
    parameter int PSUM_W      = 28,
    parameter int STORE_W     = 17,
    parameter int STORE_SHIFT = 11,
    parameter int BANKS       = 2,
    parameter int CHUNK       = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            en,
    input  logic                            init_start,
    input  logic [1:0]                      init_mode,
    input  logic [BANKS*PSUM_W-1:0]         bias_in,
    input  logic [$clog2(LANES/CHUNK)-1:0]  chunk_idx,
    input  logic [CHUNK*PSUM_W-1:0]         chunk_data,
    input  logic                            acc_vld,
    input  logic [LANES*ACC_W-1:0]          acc_data,
    input  logic                            store_en,
    output logic [LANES*PSUM_W-1:0]         psum_out,
    output logic [$clog2(BANKS)-1:0]        psum_bank,
    output logic                            init_busy,
    output logic                            store_vld,
    output logic [LANES*STORE_W-1:0]        store_data
`ifdef PSUM_SAT_CNT_EN
    ,
    output logic [15:0]                     sat_cnt
`endif
);

    localparam int PTR_W  = $clog2(BANKS);
    localparam int NCHUNK = LANES / CHUNK;
    localparam int CIDX_W = $clog2(LANES / CHUNK);
    localparam logic [PTR_W-1:0] LAST_BANK = PTR_W'(BANKS - 1);

    // Saturation bounds expressed at accumulator width for signed compares.
    localparam logic signed [ACC_W-1:0] PSUM_MAX  = {{(ACC_W-PSUM_W+1){1'b0}}, {(PSUM_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] PSUM_MIN  = ~PSUM_MAX;
    localparam logic signed [ACC_W-1:0] STORE_MAX = {{(ACC_W-STORE_W+1){1'b0}}, {(STORE_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] STORE_MIN = ~STORE_MAX;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BCAST = 2'd1,
        S_CLEAR = 2'd2
    } state_e;

    function automatic logic psum_ovf(input logic signed [ACC_W-1:0] a);
        return (a > PSUM_MAX) || (a < PSUM_MIN);
    endfunction

    function automatic logic [PSUM_W-1:0] sat_psum(input logic signed [ACC_W-1:0] a);
        logic [PSUM_W-1:0] r;
        if (a > PSUM_MAX)      r = PSUM_MAX[PSUM_W-1:0];
        else if (a < PSUM_MIN) r = PSUM_MIN[PSUM_W-1:0];
        else                   r = a[PSUM_W-1:0];
        return r;
    endfunction

    function automatic logic [STORE_W-1:0] sat_store(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] s;
        logic [STORE_W-1:0]      r;
        s = a >>> STORE_SHIFT;
        if (s > STORE_MAX)      r = STORE_MAX[STORE_W-1:0];
        else if (s < STORE_MIN) r = STORE_MIN[STORE_W-1:0];
        else                    r = s[STORE_W-1:0];
        return r;
    endfunction

    state_e                 state_q, state_d;
    logic [PTR_W-1:0]       k_q, k_d;
    logic [PTR_W-1:0]       rd_ptr_q;
    logic [PTR_W-1:0]       wr_bank_s;
    logic [PSUM_W-1:0]      bank_q [BANKS][LANES];
    logic [PSUM_W-1:0]      bank_d [BANKS][LANES];
    logic                   init_busy_q;
    logic                   store_vld_q;
    logic [LANES*STORE_W-1:0] store_data_q;
    logic [LANES*STORE_W-1:0] store_d_s;
    logic                   chunk_wr_s;
    logic                   sat_clr_s;
    logic                   seq_wr_s;
    logic                   wb_s;
    logic                   sat_any_s;

    assign wr_bank_s = (rd_ptr_q == LAST_BANK) ? '0 : rd_ptr_q + PTR_W'(1);

    // Read pointer: rotates while enabled, parked at bank 0 otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  rd_ptr_q <= '0;
        else if (en) rd_ptr_q <= wr_bank_s;
        else         rd_ptr_q <= '0;
    end

    // Init FSM state and bank counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
    end

    // Init FSM next state: walk banks 0..BANKS-1, one per cycle.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        case (state_q)
            S_IDLE: begin
                if (init_start) begin
                    case (init_mode)
                        2'd1:    begin state_d = S_BCAST; k_d = '0; end
                        2'd3:    begin state_d = S_CLEAR; k_d = '0; end
                        default: begin state_d = S_IDLE;  k_d = k_q; end
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BCAST, S_CLEAR: begin
                if (k_q == LAST_BANK) begin
                    state_d = S_IDLE;
                    k_d     = '0;
                end else begin
                    k_d = k_q + PTR_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                k_d     = '0;
            end
        endcase
    end

    // Init FSM outputs: sequence writes, immediate chunk write, counter clear.
    always_comb begin
        seq_wr_s   = (state_q == S_BCAST) || (state_q == S_CLEAR);
        chunk_wr_s = (state_q == S_IDLE) && init_start && (init_mode == 2'd2) &&
                     ({{(32-CIDX_W){1'b0}}, chunk_idx} < 32'(NCHUNK));
        sat_clr_s  = (state_q == S_IDLE) && init_start &&
                     ((init_mode == 2'd1) || (init_mode == 2'd3));
    end

    // Busy flag registered from the next state so it tracks the sequence exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) init_busy_q <= 1'b0;
        else        init_busy_q <= (state_d == S_BCAST) || (state_d == S_CLEAR);
    end

    // Bank next-state: write-back first, then init writes override; a collision drops write-back.
    always_comb begin
        bank_d    = bank_q;
        sat_any_s = 1'b0;
        if (seq_wr_s)        wb_s = acc_vld && (k_q != wr_bank_s);
        else if (chunk_wr_s) wb_s = acc_vld && (wr_bank_s != '0);
        else                 wb_s = acc_vld;
        for (int l = 0; l < LANES; l++) begin
            sat_any_s = sat_any_s | psum_ovf(acc_data[l*ACC_W +: ACC_W]);
            if (wb_s) bank_d[wr_bank_s][l] = sat_psum(acc_data[l*ACC_W +: ACC_W]);
            else      bank_d[wr_bank_s][l] = bank_d[wr_bank_s][l];
        end
        case (state_q)
            S_BCAST: for (int l = 0; l < LANES; l++) bank_d[k_q][l] = bias_in[k_q*PSUM_W +: PSUM_W];
            S_CLEAR: for (int l = 0; l < LANES; l++) bank_d[k_q][l] = '0;
            default: begin
                if (chunk_wr_s) begin
                    for (int j = 0; j < CHUNK; j++)
                        bank_d[0][int'(chunk_idx)*CHUNK + j] = chunk_data[j*PSUM_W +: PSUM_W];
                end else begin
                    bank_d[0][0] = bank_d[0][0];
                end
            end
        endcase
    end

    // Bank storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < BANKS; b++)
                for (int l = 0; l < LANES; l++)
                    bank_q[b][l] <= '0;
        end else begin
            bank_q <= bank_d;
        end
    end

    // Store-path values for every lane.
    always_comb begin
        store_d_s = '0;
        for (int l = 0; l < LANES; l++)
            store_d_s[l*STORE_W +: STORE_W] = sat_store(acc_data[l*ACC_W +: ACC_W]);
    end

    // Store-path registers: data captured on request, valid pulses one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            store_vld_q  <= 1'b0;
            store_data_q <= '0;
        end else begin
            store_vld_q <= acc_vld && store_en;
            if (acc_vld && store_en) store_data_q <= store_d_s;
            else                     store_data_q <= store_data_q;
        end
    end

    // Read-side view of the selected bank.
    always_comb begin
        psum_out = '0;
        for (int l = 0; l < LANES; l++)
            psum_out[l*PSUM_W +: PSUM_W] = bank_q[rd_ptr_q][l];
    end

    assign psum_bank  = rd_ptr_q;
    assign init_busy  = init_busy_q;
    assign store_vld  = store_vld_q;
    assign store_data = store_data_q;

`ifdef PSUM_SAT_CNT_EN
    logic [15:0] sat_cnt_q;

    // Saturation event counter: clears on accepted bias/clear start, sticks at max.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                          sat_cnt_q <= 16'd0;
        else if (sat_clr_s)                                  sat_cnt_q <= 16'd0;
        else if (wb_s && sat_any_s && (sat_cnt_q != 16'hFFFF)) sat_cnt_q <= sat_cnt_q + 16'd1;
        else                                                 sat_cnt_q <= sat_cnt_q;
    end

    assign sat_cnt = sat_cnt_q;
`else
    logic unused_sat_s;
    assign unused_sat_s = sat_clr_s ^ sat_any_s;
`endif

endmodule

// File: tb/tb_psum_pingpong_buffer.sv
// Directed self-checking bench for psum_pingpong_buffer (default parameters).
module tb_psum_pingpong_buffer;

    localparam int LANES   = 112;
    localparam int ACC_W   = 33;
    localparam int PSUM_W  = 28;
    localparam int STORE_W = 17;
    localparam int BANKS   = 2;
    localparam int CHUNK   = 4;

    logic                           clk;
    logic                           rst_n;
    logic                           en;
    logic                           init_start;
    logic [1:0]                     init_mode;
    logic [BANKS*PSUM_W-1:0]        bias_in;
    logic [$clog2(LANES/CHUNK)-1:0] chunk_idx;
    logic [CHUNK*PSUM_W-1:0]        chunk_data;
    logic                           acc_vld;
    logic [LANES*ACC_W-1:0]         acc_data;
    logic                           store_en;
    logic [LANES*PSUM_W-1:0]        psum_out;
    logic [$clog2(BANKS)-1:0]       psum_bank;
    logic                           init_busy;
    logic                           store_vld;
    logic [LANES*STORE_W-1:0]       store_data;
`ifdef PSUM_SAT_CNT_EN
    logic [15:0]                    sat_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    psum_pingpong_buffer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .init_start (init_start),
        .init_mode  (init_mode),
        .bias_in    (bias_in),
        .chunk_idx  (chunk_idx),
        .chunk_data (chunk_data),
        .acc_vld    (acc_vld),
        .acc_data   (acc_data),
        .store_en   (store_en),
        .psum_out   (psum_out),
        .psum_bank  (psum_bank),
        .init_busy  (init_busy),
        .store_vld  (store_vld),
        .store_data (store_data)
`ifdef PSUM_SAT_CNT_EN
        ,
        .sat_cnt    (sat_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled at the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [63:0] ps(input int l);
        return 64'(psum_out[l*PSUM_W +: PSUM_W]);
    endfunction

    function automatic logic [63:0] st(input int l);
        return 64'(store_data[l*STORE_W +: STORE_W]);
    endfunction

    task automatic set_acc(input int l, input logic [ACC_W-1:0] v);
        acc_data[l*ACC_W +: ACC_W] = v;
    endtask

    task automatic fill_acc(input logic [ACC_W-1:0] v);
        for (int l = 0; l < LANES; l++) acc_data[l*ACC_W +: ACC_W] = v;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; init_start = 1'b0; init_mode = 2'd0;
        bias_in = '0; chunk_idx = '0; chunk_data = '0;
        acc_vld = 1'b0; acc_data = '0; store_en = 1'b0;
        @(negedge clk);
        // Reset state.
        check_eq("rst_bank",  64'(psum_bank), 64'd0);
        check_eq("rst_busy",  64'(init_busy), 64'd0);
        check_eq("rst_svld",  64'(store_vld), 64'd0);
        check_eq("rst_sdata", st(0), 64'd0);
        check_eq("rst_ps0",   ps(0), 64'd0);
        check_eq("rst_ps111", ps(111), 64'd0);
`ifdef PSUM_SAT_CNT_EN
        check_eq("rst_satcnt", 64'(sat_cnt), 64'd0);
`endif
        rst_n = 1'b1;
        tick();

        // Broadcast bias: bank1=5, bank0=-3.
        bias_in = {28'd5, 28'hFFFFFFD};
        init_mode = 2'd1; init_start = 1'b1;
        tick();
        init_start = 1'b0;
        check_eq("bc_busy_c0", 64'(init_busy), 64'd1);
        tick();
        check_eq("bc_busy_c1", 64'(init_busy), 64'd1);
        check_eq("bc_b0_l0",   ps(0),   64'h0FFFFFFD);
        check_eq("bc_b0_l111", ps(111), 64'h0FFFFFFD);
        tick();
        check_eq("bc_busy_end", 64'(init_busy), 64'd0);
        en = 1'b1;
        tick();
        check_eq("rot_ptr1",  64'(psum_bank), 64'd1);
        check_eq("bc_b1_l0",  ps(0),  64'd5);
        check_eq("bc_b1_l50", ps(50), 64'd5);
        en = 1'b0;
        tick();
        check_eq("ptr_clr", 64'(psum_bank), 64'd0);

        // PSUM saturation into bank 1 (rd_ptr 0).
        acc_data = '0;
        set_acc(0, 33'h0_0800_0000);   // 2^27
        set_acc(1, 33'h1_F7FF_FFFF);   // -2^27-1
        set_acc(2, 33'd1234);
        acc_vld = 1'b1;
        tick();
        acc_vld = 1'b0; en = 1'b1;
        tick();
        check_eq("sat_pos", ps(0), 64'h7FFFFFF);
        check_eq("sat_neg", ps(1), 64'h8000000);
        check_eq("sat_mid", ps(2), 64'd1234);
        check_eq("wb_zero", ps(3), 64'd0);
        en = 1'b0;
        tick();

        // Store path.
        acc_data = '0;
        set_acc(0, 33'd6144);
        set_acc(1, 33'h0_4000_0000);   // 2^30
        set_acc(2, 33'h1_C000_0000);   // -2^30
        set_acc(3, 33'h1_FFFF_FFFF);   // -1
        acc_vld = 1'b1; store_en = 1'b1;
        tick();
        acc_vld = 1'b0; store_en = 1'b0;
        check_eq("st_vld",  64'(store_vld), 64'd1);
        check_eq("st_l0",   st(0), 64'd3);
        check_eq("st_l1",   st(1), 64'hFFFF);
        check_eq("st_l2",   st(2), 64'h10000);
        check_eq("st_l3",   st(3), 64'h1FFFF);
        tick();
        check_eq("st_vld_off", 64'(store_vld), 64'd0);
        check_eq("st_hold",    st(0), 64'd3);

        // Chunk write into bank 0 lanes 108..111.
        chunk_idx = 5'd27;
        chunk_data = {28'd4, 28'd3, 28'd2, 28'd1};
        init_mode = 2'd2; init_start = 1'b1;
        tick();
        init_start = 1'b0;
        check_eq("ch_busy", 64'(init_busy), 64'd0);
        for (int j = 0; j < CHUNK; j++) check_eq("ch_lane", ps(108 + j), 64'(j + 1));
        check_eq("ch_l107", ps(107), 64'h0FFFFFFD);
        // Out-of-range chunk: no write.
        chunk_idx = 5'd30;
        chunk_data = {4{28'd9}};
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        check_eq("ch_oor_l108", ps(108), 64'd1);
        check_eq("ch_oor_l0",   ps(0),   64'h0FFFFFFD);

        // Broadcast with concurrent write-back; collision on bank 1 is dropped.
        bias_in = {28'd7, 28'd11};
        init_mode = 2'd1; init_start = 1'b1;
        tick();
        init_start = 1'b0;
        fill_acc(33'd100); acc_vld = 1'b1;
        tick();
        check_eq("col_b0", ps(0), 64'd11);
        fill_acc(33'd200);
        tick();
        acc_vld = 1'b0;
        check_eq("col_busy", 64'(init_busy), 64'd0);
        en = 1'b1;
        tick();
        check_eq("col_b1_l0",   ps(0),   64'd7);
        check_eq("col_b1_l111", ps(111), 64'd7);
        en = 1'b0;
        tick();

        // Reset in the middle of a broadcast.
        bias_in = {28'd9, 28'd9};
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        tick();
        check_eq("mid_b0", ps(5), 64'd9);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_busy", 64'(init_busy), 64'd0);
        check_eq("mid_rst_b0",   ps(5), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_eq("mid_abort_busy", 64'(init_busy), 64'd0);
        en = 1'b1;
        tick();
        check_eq("mid_abort_b1", ps(5), 64'd0);
        en = 1'b0;
        tick();

        // Three saturating write-backs then a clean one, then a clear.
        fill_acc(33'd0);
        set_acc(7, 33'h0_1000_0000);   // 2^28
        acc_vld = 1'b1;
        tick(); tick(); tick();
        fill_acc(33'd0);
        set_acc(5, 33'd1234);
        tick();
        acc_vld = 1'b0;
`ifdef PSUM_SAT_CNT_EN
        check_eq("satcnt_3", 64'(sat_cnt), 64'd3);
`endif
        init_mode = 2'd3; init_start = 1'b1;
        tick();
        init_start = 1'b0;
`ifdef PSUM_SAT_CNT_EN
        check_eq("satcnt_clr", 64'(sat_cnt), 64'd0);
`endif
        check_eq("clr_busy0", 64'(init_busy), 64'd1);
        tick();
        check_eq("clr_busy1", 64'(init_busy), 64'd1);
        tick();
        check_eq("clr_busy_end", 64'(init_busy), 64'd0);
        en = 1'b1;
        tick();
        check_eq("clr_b1_l5", ps(5), 64'd0);
        check_eq("clr_b1_l7", ps(7), 64'd0);
        en = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
